pulse_window_counter_mc: RTL and testbench

Multi-channel, parametrised pulse-width discriminating event counter for the instrument signal path.
- Each channel thresholds a signed sample stream with hysteresis and measures the high-time of each pulse.
- Pulses whose width falls inside a programmable window are counted over a programmable period.
- At each period end, every channel latches its count and drives a HI/LO decision pair. Per-period counts are also exported for readout.

---
 rtl/pulse_window_counter_mc.sv | 250 +++++++++++++++++++++++++
 tb/tb_pulse_window_counter_mc.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_window_counter_mc.sv
//------------------------------------------------------------------------------
// pulse_window_counter_mc
//
// Multi-channel pulse-width discriminating event counter.
//
// Each channel compares its signed sample stream against a shared threshold
// with hysteresis. The compare result is registered as "armed". A small FSM
// measures how many clocks armed stays high. A pulse whose width falls inside
// [PulseMin, PulseMax] is counted. An optional hold-off dead time follows
// every pulse end.
//
// A shared free-running period counter defines the counting period. At each
// period end, every channel does the following:
//   - latches its accepted-pulse count and sticky saturation flag;
//   - drives a HI/LO decision pair (count >= MinPulseCount);
//   - restarts counting.
//
// Ports
//   Clk, Reset     clock, synchronous active-high reset
//   DataIn         NCH signed samples, channel k at [k*DATA_W +: DATA_W]
//   Threshold      signed rising threshold (shared)
//   Hysteresis     unsigned, falling threshold = Threshold - Hysteresis
//   PulseMin/Max   inclusive accepted width window, in clocks
//   Holdoff        dead time after each pulse end, in clocks
//   PeriodLimit    period length is PeriodLimit+1 clocks
//   MinPulseCount  decision threshold on the accepted count
//   DataOutA       per channel: max positive level if decision=1, else 0
//   DataOutB       per channel: inverse level of DataOutA
//   CountOut       per channel accepted count of the last completed period
//   CountValid     one-clock strobe when CountOut/decisions update
//   Saturated      per channel: count saturated during the last period
//------------------------------------------------------------------------------
module pulse_window_counter_mc #(
   parameter int NCH    = 2,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16,
   parameter int PER_W  = 32
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [NCH*DATA_W-1:0] DataIn,
   input  logic [DATA_W-1:0]     Threshold,
   input  logic [DATA_W-1:0]     Hysteresis,
   input  logic [CNT_W-1:0]      PulseMin,
   input  logic [CNT_W-1:0]      PulseMax,
   input  logic [CNT_W-1:0]      Holdoff,
   input  logic [PER_W-1:0]      PeriodLimit,
   input  logic [CNT_W-1:0]      MinPulseCount,
   output logic [NCH*DATA_W-1:0] DataOutA,
   output logic [NCH*DATA_W-1:0] DataOutB,
   output logic [NCH*CNT_W-1:0]  CountOut,
   output logic                  CountValid,
   output logic [NCH-1:0]        Saturated
);

   // Two guard bits keep Threshold - Hysteresis exact for any operand values.
   localparam int EXT_W = DATA_W + 2;

   localparam logic signed [DATA_W-1:0] HI_LVL  = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] LO_LVL  = '0;
   localparam logic [CNT_W-1:0]         CNT_MAX = '1;
   localparam logic [CNT_W-1:0]         CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]         CNT_TWO = CNT_W'(2);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_HOLDOFF = 2'd2
   } state_t;

   // Saturating increment used by both the width and the pulse counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Inclusive window test. An inverted window (lo > hi) accepts nothing.
   function automatic logic in_window(input logic [CNT_W-1:0] len,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (len >= lo) && (len <= hi);
   endfunction

   // Output level for one decision bit.
   function automatic logic signed [DATA_W-1:0] level_of(input logic d);
      return d ? HI_LVL : LO_LVL;
   endfunction

   //---------------------------------------------------------------------------
   // Shared thresholds, extended so the falling threshold never wraps
   //---------------------------------------------------------------------------
   logic signed [EXT_W-1:0] rise_ext;
   logic signed [EXT_W-1:0] hyst_ext;
   logic signed [EXT_W-1:0] fall_ext;

   assign rise_ext = {{2{Threshold[DATA_W-1]}}, Threshold};
   assign hyst_ext = {2'b00, Hysteresis};
   assign fall_ext = rise_ext - hyst_ext;

   //---------------------------------------------------------------------------
   // Shared period counter
   //---------------------------------------------------------------------------
   logic [PER_W-1:0] per_cnt;
   logic             per_end_p0;

   // ">=" rather than "==" recovers immediately if PeriodLimit is lowered
   // below the running count.
   assign per_end_p0 = (per_cnt >= PeriodLimit);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         per_cnt    <= '0;
         CountValid <= 1'b0;
      end else begin
         per_cnt    <= per_end_p0 ? '0 : per_cnt + 1'b1;
         CountValid <= per_end_p0;
      end
   end

   //---------------------------------------------------------------------------
   // Per-channel datapath
   //---------------------------------------------------------------------------
   for (genvar k = 0; k < NCH; k++) begin : g_ch

      logic signed [DATA_W-1:0] smp;
      logic signed [EXT_W-1:0]  smp_ext;
      logic                     armed_p0;

      state_t                   state;
      state_t                   state_nxt;
      logic [CNT_W-1:0]         len_q;
      logic [CNT_W-1:0]         hold_q;
      logic                     pulse_end;
      logic                     win_ok;
      logic                     accept_vld_p1;

      logic [CNT_W-1:0]         cnt_p2;
      logic [CNT_W-1:0]         cnt_nxt;
      logic                     sticky_p2;
      logic                     ovf;

      logic [CNT_W-1:0]         cnt_out_q;
      logic                     dec_q;
      logic                     sat_q;

      assign smp     = DataIn[k*DATA_W +: DATA_W];
      assign smp_ext = {{2{smp[DATA_W-1]}}, smp};

      // ---- stage p0: hysteresis comparator -------------------------------
      // Samples between the two thresholds leave the armed state unchanged.
      always_ff @(posedge Clk) begin
         if (Reset) begin
            armed_p0 <= 1'b0;
         end else if (smp_ext > rise_ext) begin
            armed_p0 <= 1'b1;
         end else if (smp_ext < fall_ext) begin
            armed_p0 <= 1'b0;
         end
      end

      // ---- stage p1: width-measurement FSM -------------------------------
      always_ff @(posedge Clk) begin
         if (Reset) begin
            state         <= S_IDLE;
            accept_vld_p1 <= 1'b0;
         end else begin
            state         <= state_nxt;
            accept_vld_p1 <= pulse_end && win_ok;
         end
      end

      // The IDLE clock that sees armed high is already the first clock of the
      // pulse, so the width restarts at 1. In HOLDOFF, the armed input is
      // ignored entirely.
      always_ff @(posedge Clk) begin
         if (state == S_IDLE) begin
            len_q <= CNT_ONE;
         end else if (state == S_MEASURE && armed_p0) begin
            len_q <= sat_inc(len_q);
         end

         if (state == S_MEASURE) begin
            hold_q <= Holdoff;
         end else if (state == S_HOLDOFF) begin
            hold_q <= hold_q - 1'b1;
         end
      end

      always_comb begin
         state_nxt = state;
         case (state)
            S_IDLE: begin
               if (armed_p0) begin
                  state_nxt = S_MEASURE;
               end
            end
            S_MEASURE: begin
               if (!armed_p0) begin
                  state_nxt = (Holdoff == '0) ? S_IDLE : S_HOLDOFF;
               end
            end
            S_HOLDOFF: begin
               // Leave once the count would drop to 1. The pulse-end clock
               // already used one clock of the dead time.
               if (hold_q <= CNT_TWO) begin
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end

      always_comb begin
         pulse_end = (state == S_MEASURE) && !armed_p0;
         win_ok    = in_window(len_q, PulseMin, PulseMax);
      end

      // ---- stage p2: pulse counter and period-end latch ------------------
      // An accept that coincides with the period-end clock is folded into the
      // latched count. The counter restarts from zero on that clock.
      assign cnt_nxt = accept_vld_p1 ? sat_inc(cnt_p2) : cnt_p2;
      assign ovf     = accept_vld_p1 && (cnt_p2 == CNT_MAX);

      always_ff @(posedge Clk) begin
         if (Reset) begin
            cnt_p2    <= '0;
            sticky_p2 <= 1'b0;
            cnt_out_q <= '0;
            dec_q     <= 1'b0;
            sat_q     <= 1'b0;
         end else if (per_end_p0) begin
            cnt_out_q <= cnt_nxt;
            dec_q     <= (cnt_nxt >= MinPulseCount);
            sat_q     <= sticky_p2 | ovf;
            cnt_p2    <= '0;
            sticky_p2 <= 1'b0;
         end else begin
            cnt_p2    <= cnt_nxt;
            sticky_p2 <= sticky_p2 | ovf;
         end
      end

      // ---- outputs ----------------------------------------------------------
      assign DataOutA[k*DATA_W +: DATA_W] = level_of(dec_q);
      assign DataOutB[k*DATA_W +: DATA_W] = level_of(!dec_q);
      assign CountOut[k*CNT_W +: CNT_W]   = cnt_out_q;
      assign Saturated[k]                 = sat_q;

   end : g_ch

endmodule

// File: tb/tb_pulse_window_counter_mc.sv
module tb_pulse_window_counter_mc;

   localparam int NCH  = 2;
   localparam int DW   = 16;
   localparam int CW   = 16;
   localparam int PW   = 32;
   localparam int HI   = 32767;
   localparam int HI_S = 1100;
   localparam int LO_S = 900;
   localparam int RN   = 1200;

   logic                 Clk = 1'b0;
   logic                 Reset = 1'b1;
   logic [NCH*DW-1:0]    DataIn = '0;
   logic [DW-1:0]        Threshold = '0;
   logic [DW-1:0]        Hysteresis = '0;
   logic [CW-1:0]        PulseMin = '0;
   logic [CW-1:0]        PulseMax = '0;
   logic [CW-1:0]        Holdoff = '0;
   logic [PW-1:0]        PeriodLimit = '0;
   logic [CW-1:0]        MinPulseCount = '0;
   logic [NCH*DW-1:0]    DataOutA, DataOutB;
   logic [NCH*CW-1:0]    CountOut;
   logic                 CountValid;
   logic [NCH-1:0]       Saturated;

   // 4-bit counter instance for the saturation corner case
   logic [3:0]           PulseMin4, PulseMax4, Holdoff4, MinPulseCount4;
   logic [NCH*DW-1:0]    DataOutA4, DataOutB4;
   logic [NCH*4-1:0]     CountOut4;
   logic                 CountValid4;
   logic [NCH-1:0]       Saturated4;

   assign PulseMin4      = PulseMin[3:0];
   assign PulseMax4      = PulseMax[3:0];
   assign Holdoff4       = Holdoff[3:0];
   assign MinPulseCount4 = MinPulseCount[3:0];

   always #5 Clk = ~Clk;

   pulse_window_counter_mc #(.NCH(NCH), .DATA_W(DW), .CNT_W(CW), .PER_W(PW)) dut (
      .Clk(Clk), .Reset(Reset), .DataIn(DataIn), .Threshold(Threshold),
      .Hysteresis(Hysteresis), .PulseMin(PulseMin), .PulseMax(PulseMax),
      .Holdoff(Holdoff), .PeriodLimit(PeriodLimit), .MinPulseCount(MinPulseCount),
      .DataOutA(DataOutA), .DataOutB(DataOutB), .CountOut(CountOut),
      .CountValid(CountValid), .Saturated(Saturated));

   pulse_window_counter_mc #(.NCH(NCH), .DATA_W(DW), .CNT_W(4), .PER_W(PW)) dut4 (
      .Clk(Clk), .Reset(Reset), .DataIn(DataIn), .Threshold(Threshold),
      .Hysteresis(Hysteresis), .PulseMin(PulseMin4), .PulseMax(PulseMax4),
      .Holdoff(Holdoff4), .PeriodLimit(PeriodLimit), .MinPulseCount(MinPulseCount4),
      .DataOutA(DataOutA4), .DataOutB(DataOutB4), .CountOut(CountOut4),
      .CountValid(CountValid4), .Saturated(Saturated4));

   int n_chk  = 0;
   int n_pass = 0;
   int cur_thr = 1000;
   int cur_hyst = 0;

   // Record fields: pulse widths on ch0 (0 = none), PulseMin, PulseMax,
   // MinPulseCount, expected CountOut[ch0], expected DataOutA[ch0].
   typedef struct {
      int w[4];
      int pmin;
      int pmax;
      int minc;
      int exp_cnt;
      int exp_a;
   } vec_t;

   vec_t tbl[6];

   int  samp[NCH][RN];
   bit  arm[RN+1];
   int  ecnt[NCH][128];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int cnt_of(input int ch);
      return int'(CountOut[ch*CW +: CW]);
   endfunction
   function automatic int a_of(input int ch);
      return int'(DataOutA[ch*DW +: DW]);
   endfunction
   function automatic int b_of(input int ch);
      return int'(DataOutB[ch*DW +: DW]);
   endfunction

   task automatic set_ch(input int ch, input int v);
      DataIn[ch*DW +: DW] = 16'(v);
   endtask

   task automatic cfg(input int thr, input int hyst, input int pmin, input int pmax,
                      input int hold, input int per, input int minc);
      cur_thr = thr;
      cur_hyst = hyst;
      Threshold = 16'(thr);
      Hysteresis = 16'(hyst);
      PulseMin = 16'(pmin);
      PulseMax = 16'(pmax);
      Holdoff = 16'(hold);
      PeriodLimit = 32'(per);
      MinPulseCount = 16'(minc);
   endtask

   // Leaves the bench in the first clock after reset (period counter = 0).
   task automatic do_reset();
      Reset = 1'b1;
      for (int ch = 0; ch < NCH; ch++) set_ch(ch, cur_thr - cur_hyst - 1);
      tick();
      tick();
      Reset = 1'b0;
   endtask

   task automatic pulse(input int ch, input int w, input int gap);
      set_ch(ch, HI_S);
      repeat (w) tick();
      set_ch(ch, LO_S);
      repeat (gap) tick();
   endtask

   task automatic wait_valid(input int budget, input string name);
      int n = 0;
      while (CountValid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      if (CountValid !== 1'b1) check({name, " timeout"}, 0, 1);
   endtask

   // Random stimulus against an event-level model: armed intervals are
   // derived from the threshold rule, then each interval is turned into a
   // measured width (trimmed by any hold-off window) and binned by period.
   task automatic run_random(input int iter);
      int thr, hyst, pmin, pmax, hold, per, minc, dd;
      int c, a, b, m, len, idle_from, mode, seg, v, j, e;
      thr  = int'($urandom_range(4000, 0)) - 2000;
      hyst = int'($urandom_range(300, 0));
      pmin = int'($urandom_range(12, 1));
      pmax = pmin + int'($urandom_range(15, 0)) - 2;
      if (pmax < 0) pmax = 0;
      case ($urandom_range(5, 0))
         0, 1:    hold = 0;
         2:       hold = 1;
         3:       hold = 2;
         default: hold = int'($urandom_range(9, 3));
      endcase
      per  = int'($urandom_range(60, 20));
      minc = int'($urandom_range(6, 0));
      dd   = (hold <= 2) ? 1 : hold - 1;
      cfg(thr, hyst, pmin, pmax, hold, per, minc);

      for (int ch = 0; ch < NCH; ch++) begin
         c = 0;
         while (c < RN) begin
            mode = int'($urandom_range(2, 0));
            seg  = int'($urandom_range(15, 1));
            for (int k = 0; k < seg && c < RN; k++) begin
               if (mode == 0)                   v = thr + 1 + int'($urandom_range(500, 0));
               else if (mode == 1 || hyst == 0) v = thr - hyst - 1 - int'($urandom_range(500, 0));
               else                             v = thr - int'($urandom_range(hyst, 0));
               samp[ch][c] = v;
               c++;
            end
         end

         for (int i = 0; i < 128; i++) ecnt[ch][i] = 0;
         arm[0] = 1'b0;
         for (int i = 0; i < RN; i++) begin
            if (samp[ch][i] > thr)             arm[i+1] = 1'b1;
            else if (samp[ch][i] < thr - hyst) arm[i+1] = 1'b0;
            else                               arm[i+1] = arm[i];
         end
         idle_from = 0;
         c = 1;
         while (c <= RN) begin
            if (!arm[c]) begin
               c++;
            end else begin
               a = c;
               while (c <= RN && arm[c]) c++;
               if (c <= RN) begin
                  b = c - 1;
                  m = (a > idle_from) ? a : idle_from;
                  if (m <= b) begin
                     len = b - m + 1;
                     if (len > 65535) len = 65535;
                     if (len >= pmin && len <= pmax) ecnt[ch][(b + 2) / (per + 1)]++;
                     idle_from = b + 2 + ((hold == 0) ? 0 : dd);
                  end
               end
            end
         end
      end

      do_reset();
      for (int cc = 0; cc < RN; cc++) begin
         for (int ch = 0; ch < NCH; ch++) set_ch(ch, samp[ch][cc]);
         check($sformatf("rand%0d valid c%0d", iter, cc), int'(CountValid),
               (cc > 0 && cc % (per + 1) == 0) ? 1 : 0);
         if (cc > 0 && cc % (per + 1) == 0) begin
            j = cc / (per + 1) - 1;
            for (int ch = 0; ch < NCH; ch++) begin
               e = ecnt[ch][j];
               check($sformatf("rand%0d count ch%0d p%0d", iter, ch, j), cnt_of(ch), e);
               check($sformatf("rand%0d dataA ch%0d p%0d", iter, ch, j), a_of(ch),
                     (e >= minc) ? HI : 0);
               check($sformatf("rand%0d sat ch%0d p%0d", iter, ch, j), int'(Saturated[ch]), 0);
            end
         end
         tick();
      end
   endtask

   initial begin
      tbl[0] = '{'{14, 15, 31, 32}, 15, 31, 3, 2, 0};
      tbl[1] = '{'{14, 15, 31, 32}, 15, 31, 2, 2, HI};
      tbl[2] = '{'{20, 20, 20, 0},  25, 15, 1, 0, 0};
      tbl[3] = '{'{1, 2, 3, 0},     1,  2,  2, 2, HI};
      tbl[4] = '{'{16, 16, 16, 16}, 16, 16, 4, 4, HI};
      tbl[5] = '{'{20, 20, 0, 0},   30, 40, 0, 0, HI};

      // Reset state
      cfg(1000, 0, 15, 31, 0, 999, 3);
      do_reset();
      for (int ch = 0; ch < NCH; ch++) begin
         check($sformatf("reset count ch%0d", ch), cnt_of(ch), 0);
         check($sformatf("reset dataA ch%0d", ch), a_of(ch), 0);
         check($sformatf("reset dataB ch%0d", ch), b_of(ch), HI);
      end
      check("reset valid", int'(CountValid), 0);
      check("reset sat", int'(Saturated), 0);

      // Table-driven window / decision vectors on ch0
      for (int t = 0; t < 6; t++) begin
         cfg(1000, 0, tbl[t].pmin, tbl[t].pmax, 0, 999, tbl[t].minc);
         do_reset();
         for (int p = 0; p < 4; p++) if (tbl[t].w[p] > 0) pulse(0, tbl[t].w[p], 10);
         wait_valid(1100, $sformatf("tbl%0d", t));
         check($sformatf("tbl%0d count ch0", t), cnt_of(0), tbl[t].exp_cnt);
         check($sformatf("tbl%0d dataA ch0", t), a_of(0), tbl[t].exp_a);
         check($sformatf("tbl%0d dataB ch0", t), b_of(0), HI - tbl[t].exp_a);
         check($sformatf("tbl%0d count ch1", t), cnt_of(1), 0);
      end

      // Decision high on ch0, ch1 independent, single strobe
      cfg(1000, 0, 15, 31, 0, 999, 3);
      do_reset();
      repeat (5) pulse(0, 20, 10);
      wait_valid(1100, "indep");
      check("indep count ch0", cnt_of(0), 5);
      check("indep dataA ch0", a_of(0), HI);
      check("indep dataB ch0", b_of(0), 0);
      check("indep count ch1", cnt_of(1), 0);
      check("indep dataA ch1", a_of(1), 0);
      check("indep dataB ch1", b_of(1), HI);
      tick();
      check("indep strobe width", int'(CountValid), 0);

      // Hysteresis: the 900 dip holds armed with Hysteresis=200, one 25-clk pulse
      for (int hv = 0; hv < 2; hv++) begin
         if (hv == 0) cfg(1000, 200, 25, 25, 0, 999, 1);
         else         cfg(1000, 0, 10, 10, 0, 999, 1);
         do_reset();
         set_ch(0, 1100); repeat (10) tick();
         set_ch(0, 900);  repeat (5) tick();
         set_ch(0, 1100); repeat (10) tick();
         set_ch(0, 700);
         wait_valid(1100, $sformatf("hyst%0d", hv));
         check($sformatf("hyst%0d count", hv), cnt_of(0), (hv == 0) ? 1 : 2);
      end

      // Holdoff trims the second pulse to 15 clks
      for (int hv = 0; hv < 2; hv++) begin
         cfg(1000, 0, 15 + hv, 31, 10, 999, 1);
         do_reset();
         pulse(0, 20, 5);
         pulse(0, 20, 10);
         wait_valid(1100, $sformatf("holdoff%0d", hv));
         check($sformatf("holdoff pmin%0d count", 15 + hv), cnt_of(0), (hv == 0) ? 2 : 1);
      end

      // Pulse spanning the period end is counted in the next period
      cfg(1000, 0, 15, 31, 0, 99, 1);
      do_reset();
      for (int c = 0; c <= 200; c++) begin
         set_ch(0, (c >= 85 && c < 105) ? HI_S : LO_S);
         if (c == 100) begin
            check("boundary valid p0", int'(CountValid), 1);
            check("boundary count p0", cnt_of(0), 0);
         end
         if (c == 200) begin
            check("boundary valid p1", int'(CountValid), 1);
            check("boundary count p1", cnt_of(0), 1);
         end
         tick();
      end

      // Saturation: 20 accepted pulses, 16-bit and 4-bit counters
      cfg(1000, 0, 3, 10, 0, 999, 15);
      do_reset();
      repeat (20) pulse(0, 5, 3);
      wait_valid(1100, "sat");
      check("sat cnt16 count", cnt_of(0), 20);
      check("sat cnt16 flag", int'(Saturated[0]), 0);
      check("sat cnt16 dataA", a_of(0), HI);
      check("sat cnt4 count", int'(CountOut4[3:0]), 15);
      check("sat cnt4 flag", int'(Saturated4[0]), 1);
      check("sat cnt4 dataA", int'(DataOutA4[DW-1:0]), HI);
      tick();
      wait_valid(1100, "sat clear");
      check("sat clear cnt4 count", int'(CountOut4[3:0]), 0);
      check("sat clear cnt4 flag", int'(Saturated4[0]), 0);
      check("sat clear cnt4 dataA", int'(DataOutA4[DW-1:0]), 0);

      // Reset mid-MEASURE discards the pulse and clears the outputs
      cfg(1000, 0, 15, 31, 0, 49, 0);
      do_reset();
      wait_valid(100, "rst pre");
      check("rst pre dataA", a_of(0), HI);
      set_ch(0, HI_S);
      repeat (18) tick();
      Reset = 1'b1;
      MinPulseCount = 16'd1;
      set_ch(0, LO_S);
      tick();
      check("rst dataA", a_of(0), 0);
      check("rst dataB", b_of(0), HI);
      check("rst count", cnt_of(0), 0);
      check("rst valid", int'(CountValid), 0);
      Reset = 1'b0;
      wait_valid(100, "rst post");
      check("rst post count", cnt_of(0), 0);
      check("rst post dataA", a_of(0), 0);

      // Randomized runs against the event-level model
      for (int it = 0; it < 2; it++) run_random(it);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
